// File: rtl/yblock_cfg_loader.sv
// Configuration loader for a yellow-cell block: accepts row-wide words over valid/ready,
// strobes each onto the block column bus with programmable setup/pulse/hold timing, and returns readback.
module yblock_cfg_loader #(
    parameter int BLOCKWIDTH  = 8,
    parameter int BLOCKHEIGHT = 8,
    parameter int CELLBITS    = 3,
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 1,
    parameter int HOLD_CYC    = 1,
    parameter int RESET_CYC   = 2,
    parameter int CW          = $clog2(BLOCKHEIGHT * CELLBITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [BLOCKWIDTH-1:0] cfg_data,
    output logic                  blk_reset,
    output logic                  confclk,
    output logic [BLOCKWIDTH-1:0] cbitout,
    input  logic [BLOCKWIDTH-1:0] cbitret,
    output logic                  ret_valid,
    output logic [BLOCKWIDTH-1:0] ret_data,
    output logic                  done,
    output logic [CW-1:0]         count
);

    localparam int NWORDS = BLOCKHEIGHT * CELLBITS;
    localparam int PMAX   = (SETUP_CYC > PULSE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int PW     = $clog2(PMAX + 1);
    localparam int RW     = $clog2(RESET_CYC + 1);

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [PW-1:0]         ph_q, ph_d;
    logic                  blk_reset_q, blk_reset_d;
    logic                  confclk_q, confclk_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  ret_valid_q, ret_valid_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BLOCKWIDTH-1:0] cbitout_q, cbitout_d;
    logic [BLOCKWIDTH-1:0] ret_data_q, ret_data_d;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        ph_d        = ph_q;
        cbitout_d   = cbitout_q;
        ret_data_d  = ret_data_q;
        count_d     = count_q;
        done_d      = done_q;
        ret_valid_d = 1'b0;
        confclk_d   = 1'b0;
        blk_reset_d = 1'b0;
        cfg_ready_d = 1'b0;

        if (clear) begin
            state_d   = ST_CLR;
            rst_cnt_d = RW'(RESET_CYC);
            count_d   = '0;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_CLR: begin
                    if (rst_cnt_q <= RW'(1)) state_d = ST_IDLE;
                    else                     rst_cnt_d = rst_cnt_q - RW'(1);
                end
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        cbitout_d = cfg_data;
                        state_d   = ST_SETUP;
                        ph_d      = PW'(SETUP_CYC);
                    end
                end
                ST_SETUP: begin
                    if (ph_q <= PW'(1)) begin
                        state_d = ST_HIGH;
                        ph_d    = PW'(PULSE_CYC);
                    end else begin
                        ph_d = ph_q - PW'(1);
                    end
                end
                ST_HIGH: begin
                    if (ph_q <= PW'(1)) begin
                        state_d = ST_HOLD;
                        ph_d    = PW'(HOLD_CYC);
                    end else begin
                        ph_d = ph_q - PW'(1);
                    end
                end
                ST_HOLD: begin
                    if (ph_q <= PW'(1)) begin
                        state_d = ST_IDLE;
                        if (count_q != CW'(NWORDS)) count_d = count_q + CW'(1);
                    end else begin
                        ph_d = ph_q - PW'(1);
                    end
                end
                default: state_d = ST_CLR;
            endcase
        end

        // Outputs are registered, so they are derived from the state being entered.
        blk_reset_d = (state_d == ST_CLR);
        confclk_d   = (state_d == ST_HIGH);
        if (state_d == ST_IDLE && count_d == CW'(NWORDS)) done_d = 1'b1;
        cfg_ready_d = (state_d == ST_IDLE) && !done_d;
        // Capture the block's bottom row before the rising confclk shifts it.
        ret_valid_d = confclk_d && !confclk_q;
        if (ret_valid_d) ret_data_d = cbitret;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLR;
            rst_cnt_q   <= RW'(RESET_CYC);
            ph_q        <= '0;
            blk_reset_q <= 1'b1;
            confclk_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            ret_valid_q <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            cbitout_q   <= '0;
            ret_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            ph_q        <= ph_d;
            blk_reset_q <= blk_reset_d;
            confclk_q   <= confclk_d;
            cfg_ready_q <= cfg_ready_d;
            ret_valid_q <= ret_valid_d;
            done_q      <= done_d;
            count_q     <= count_d;
            cbitout_q   <= cbitout_d;
            ret_data_q  <= ret_data_d;
        end
    end

    assign blk_reset = blk_reset_q;
    assign confclk   = confclk_q;
    assign cfg_ready = cfg_ready_q;
    assign ret_valid = ret_valid_q;
    assign ret_data  = ret_data_q;
    assign done      = done_q;
    assign count     = count_q;
    assign cbitout   = cbitout_q;

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Directed bench for yblock_cfg_loader at default parameters (24 words, 1/1/1 timing, 2-cycle clear).
module tb_yblock_cfg_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       blk_reset;
    logic       confclk;
    logic [7:0] cbitout;
    logic [7:0] cbitret;
    logic       ret_valid;
    logic [7:0] ret_data;
    logic       done;
    logic [4:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_cbit;
    int         exp_count;

    always #5 clk = ~clk;

    yblock_cfg_loader #(
        .BLOCKWIDTH (8),
        .BLOCKHEIGHT(8),
        .CELLBITS   (3),
        .SETUP_CYC  (1),
        .PULSE_CYC  (1),
        .HOLD_CYC   (1),
        .RESET_CYC  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .blk_reset(blk_reset),
        .confclk  (confclk),
        .cbitout  (cbitout),
        .cbitret  (cbitret),
        .ret_valid(ret_valid),
        .ret_data (ret_data),
        .done     (done),
        .count    (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Holds cfg_valid high with cfg_data changing every cycle; one word per 4-cycle period.
    // Entered and left at posedge+1 of an IDLE cycle with cfg_ready expected high.
    task automatic run_stream(input int nw, input logic [7:0] seed);
        for (int k = 0; k < nw * 4; k++) begin
            int ph;
            ph        = k % 4;
            cfg_valid = 1'b1;
            cfg_data  = seed + 8'(k * 29);
            @(negedge clk);
            check("stream_ready",   cfg_ready, (ph == 0));
            check("stream_confclk", confclk,   (ph == 2));
            check("stream_cbitout", cbitout,   exp_cbit);
            check("stream_blkrst",  blk_reset, 0);
            if (ph == 0) begin
                check("stream_count", count, exp_count);
                exp_cbit = cfg_data;
            end
            if (ph == 3) exp_count++;
            next_cycle();
            if (ph == 0) begin
                @(negedge clk);
                check("stream_accept_cbitout", cbitout, exp_cbit);
                @(posedge clk);
                #1;
                k++;
                cfg_data = seed + 8'(k * 29);
                @(negedge clk);
                check("stream_high", confclk, 1);
                check("stream_cbit_hold", cbitout, exp_cbit);
                @(posedge clk);
                #1;
                k++;
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        cbitret   = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_blk_reset", blk_reset, 1);
        check("rst_confclk",   confclk,   0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_count",     count,     0);
        check("rst_done",      done,      0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_ret_data",  ret_data,  0);
        check("rst_cbitout",   cbitout,   0);

        // Release: blk_reset for two cycles, ready on the third
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rel1_blk_reset", blk_reset, 1);
        check("rel1_ready",     cfg_ready, 0);
        check("rel1_confclk",   confclk,   0);
        next_cycle();
        @(negedge clk);
        check("rel2_blk_reset", blk_reset, 1);
        check("rel2_ready",     cfg_ready, 0);
        next_cycle();
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        cbitret   = 8'h3C;
        @(negedge clk);
        check("rel3_blk_reset", blk_reset, 0);
        check("rel3_ready",     cfg_ready, 1);
        check("rel3_count",     count,     0);

        // Single word A5 with readback of 3C
        next_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("w1_cbitout_t1", cbitout, 8'hA5);
        check("w1_confclk_t1", confclk, 0);
        check("w1_ready_t1",   cfg_ready, 0);
        next_cycle();
        cbitret = 8'hFF;
        @(negedge clk);
        check("w1_confclk_t2",   confclk,   1);
        check("w1_ret_valid_t2", ret_valid, 1);
        check("w1_ret_data_t2",  ret_data,  8'h3C);
        next_cycle();
        @(negedge clk);
        check("w1_confclk_t3",   confclk,   0);
        check("w1_ret_valid_t3", ret_valid, 0);
        check("w1_ret_data_t3",  ret_data,  8'h3C);
        check("w1_ready_t3",     cfg_ready, 0);
        next_cycle();

        // Remaining 23 words back-to-back with data toggling while busy
        exp_cbit  = 8'hA5;
        exp_count = 1;
        run_stream(23, 8'h11);

        // 25th word is held off
        for (int i = 0; i < 8; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'(i * 7 + 3);
            @(negedge clk);
            check("full_done",    done,      1);
            check("full_count",   count,     24);
            check("full_ready",   cfg_ready, 0);
            check("full_confclk", confclk,   0);
            check("full_cbitout", cbitout,   exp_cbit);
            next_cycle();
        end

        // Clear from the fully loaded state
        cfg_valid = 1'b0;
        clear     = 1'b1;
        next_cycle();
        clear = 1'b0;
        @(negedge clk);
        check("clr_blk_reset", blk_reset, 1);
        check("clr_count",     count,     0);
        check("clr_done",      done,      0);
        check("clr_confclk",   confclk,   0);
        check("clr_cbitout",   cbitout,   exp_cbit);
        next_cycle();
        @(negedge clk);
        check("clr2_blk_reset", blk_reset, 1);
        next_cycle();

        exp_count = 0;
        run_stream(9, 8'h40);

        // Word 10, clear asserted during its confclk pulse
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        cbitret   = 8'h77;
        @(negedge clk);
        check("w10_ready", cfg_ready, 1);
        check("w10_count", count,     9);
        next_cycle();
        cfg_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("w10_confclk",  confclk,  1);
        check("w10_ret_data", ret_data, 8'h77);
        #1;
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        @(negedge clk);
        check("midclr_confclk",   confclk,   0);
        check("midclr_blk_reset", blk_reset, 1);
        check("midclr_count",     count,     0);
        check("midclr_done",      done,      0);
        check("midclr_ret_valid", ret_valid, 0);
        check("midclr_cbitout",   cbitout,   8'h5A);
        check("midclr_ret_data",  ret_data,  8'h77);
        next_cycle();
        @(negedge clk);
        check("midclr2_blk_reset", blk_reset, 1);
        check("midclr2_ready",     cfg_ready, 0);
        next_cycle();
        @(negedge clk);
        check("midclr3_blk_reset", blk_reset, 0);
        check("midclr3_ready",     cfg_ready, 1);

        // Clear and handshake in the same cycle: clear wins
        next_cycle();
        cfg_valid = 1'b1;
        cfg_data  = 8'hC3;
        clear     = 1'b1;
        @(negedge clk);
        check("race_ready", cfg_ready, 1);
        next_cycle();
        clear     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        check("race_blk_reset", blk_reset, 1);
        check("race_cbitout",   cbitout,   8'h5A);
        check("race_confclk",   confclk,   0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("race_ready_back", cfg_ready, 1);
        check("race_cbitout2",   cbitout,   8'h5A);

        // Async reset during the confclk pulse
        next_cycle();
        cfg_valid = 1'b1;
        cfg_data  = 8'h81;
        next_cycle();
        cfg_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("arst_pre_confclk", confclk, 1);
        check("arst_pre_cbitout", cbitout, 8'h81);
        #1;
        reset = 1'b0;
        #1;
        check("arst_confclk",   confclk,   0);
        check("arst_blk_reset", blk_reset, 1);
        check("arst_count",     count,     0);
        check("arst_cbitout",   cbitout,   0);
        check("arst_ready",     cfg_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
